// File: rtl/score_seg_tx_pkg.sv
// Shared types and constants for the score 7-segment serial transmitter.
// Contents: FSM state enum, frame geometry, blank/dash codes, digit glyph table.
package score_seg_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned BIT_IDX_W  = 6;

    localparam logic [7:0] BLANK = 8'hFF;
    localparam logic [7:0] DASH  = 8'hBF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for digit n.
    localparam logic [9:0][7:0] GLYPH = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment glyph.
// Ports: bcd   - 4-bit digit value
//        blank - suppress the digit (leading zero)
//        seg   - 8-bit glyph {dp,g,f,e,d,c,b,a}, active-low
module bcd_to_seg
    import score_seg_tx_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [7:0] seg
);

    // An invalid nibble always shows a dash, even when blanking is requested.
    always_comb begin
        if (bcd > 4'd9) begin
            seg = DASH;
        end else if (blank) begin
            seg = BLANK;
        end else begin
            seg = GLYPH[bcd];
        end
    end

endmodule

// File: rtl/score_seg_tx.sv
// Serialises a 3-digit BCD score into a 64-bit frame for an external chain of
// 7-segment shift registers, then strobes the parallel load.
// Ports: clk, rst (sync, active-high)
//        score[11:0] - {hundreds,tens,ones} BCD
//        start       - one-cycle transmit request
//        busy, done  - frame in progress / one-cycle completion pulse
//        seg_clk, seg_dout, seg_pen, seg_clrn - external shift-register interface
module score_seg_tx
    import score_seg_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] score,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        seg_clk,
    output logic        seg_dout,
    output logic        seg_pen,
    output logic        seg_clrn
);

    localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(FRAME_BITS - 1);

    state_t                 state, state_n;
    logic [DIV_W-1:0]       div_cnt, div_cnt_n;
    logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_n;
    logic                   phase, phase_n;
    logic [FRAME_BITS-1:0]  frame, frame_n;
    logic [11:0]            last_sent, last_sent_n;
    logic                   busy_n, done_n, seg_clk_n, seg_dout_n, seg_pen_n;

    logic [7:0] d2, d1, d0;
    logic       hund_zero, tens_zero;

    // Leading-zero suppression for the hundreds and tens digits.
    assign hund_zero = (score[11:8] == 4'd0);
    assign tens_zero = (score[7:4] == 4'd0);

    bcd_to_seg u_d2 (.bcd(score[11:8]), .blank(hund_zero),             .seg(d2));
    bcd_to_seg u_d1 (.bcd(score[7:4]),  .blank(hund_zero && tens_zero), .seg(d1));
    bcd_to_seg u_d0 (.bcd(score[3:0]),  .blank(1'b0),                  .seg(d0));

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_idx   <= '0;
            phase     <= 1'b0;
            frame     <= '0;
            last_sent <= 12'hFFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_clk   <= 1'b0;
            seg_dout  <= 1'b0;
            seg_pen   <= 1'b0;
            seg_clrn  <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            bit_idx   <= bit_idx_n;
            phase     <= phase_n;
            frame     <= frame_n;
            last_sent <= last_sent_n;
            busy      <= busy_n;
            done      <= done_n;
            seg_clk   <= seg_clk_n;
            seg_dout  <= seg_dout_n;
            seg_pen   <= seg_pen_n;
            seg_clrn  <= 1'b1;
        end
    end

    // Next-state, counter and output decode. The frame register shifts left so
    // the current bit is always at the MSB; dout moves only when a new low phase
    // begins, keeping it stable around the following seg_clk rising edge.
    always_comb begin
        state_n     = state;
        div_cnt_n   = div_cnt;
        bit_idx_n   = bit_idx;
        phase_n     = phase;
        frame_n     = frame;
        last_sent_n = last_sent;
        seg_dout_n  = seg_dout;

        case (state)
            IDLE: begin
                if (start || (score != last_sent)) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                last_sent_n = score;
                frame_n     = {{5{BLANK}}, d2, d1, d0};
                div_cnt_n   = '0;
                bit_idx_n   = '0;
                phase_n     = 1'b0;
                seg_dout_n  = frame_n[FRAME_BITS-1];
                state_n     = SHIFT;
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (bit_idx == BIT_LAST) begin
                            state_n = LATCH;
                        end else begin
                            bit_idx_n  = bit_idx + BIT_IDX_W'(1);
                            frame_n    = {frame[FRAME_BITS-2:0], 1'b0};
                            seg_dout_n = frame_n[FRAME_BITS-1];
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    state_n   = DONE;
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n    = (state_n == LOAD) || (state_n == SHIFT) || (state_n == LATCH);
        done_n    = (state_n == DONE);
        seg_pen_n = (state_n == LATCH);
        seg_clk_n = (state_n == SHIFT) && phase_n;
    end

endmodule

// File: tb/tb_score_seg_tx.sv
// Scoreboard bench for score_seg_tx: stimulus pushes expected frames, a monitor
// reconstructs each frame from seg_clk/seg_dout and compares at the latch strobe.
module tb_score_seg_tx;

    localparam int CLK_DIV = 2;
    localparam int LAT     = 2 + 129 * CLK_DIV;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [11:0] score = 12'h000;
    logic        start = 1'b0;
    logic        busy, done, seg_clk, seg_dout, seg_pen, seg_clrn;

    score_seg_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .seg_clk  (seg_clk),
        .seg_dout (seg_dout),
        .seg_pen  (seg_pen),
        .seg_clrn (seg_clrn)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    int          bitcnt;
    int          pen_len;
    int          pen_pulses;
    int          done_cnt;
    logic [63:0] shreg;
    logic        prev_clk;
    logic        prev_dout;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges (starting from n0) until done is seen; exp_lat < 0 skips the latency compare.
    task automatic wait_done(input int n0, input int exp_lat, input string name);
        int n;
        bit seen;
        n    = n0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        if (exp_lat < 0) chk(seen, name, 64'(n), 64'(exp_lat));
        else             chk(seen && (n == exp_lat), name, 64'(n), 64'(exp_lat));
    endtask

    task automatic wait_bits(input int k, input string name);
        int n;
        n = 0;
        while (bitcnt < k && n < 1000) begin
            tick();
            n++;
        end
        chk(bitcnt == k, name, 64'(bitcnt), 64'(k));
    endtask

    // Drives a new score and optional start during one IDLE cycle.
    task automatic fire(input logic [11:0] sc, input bit st);
        score = sc;
        start = st;
        tick();
        start = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (3) tick();
        chk(!busy, name, 64'(busy), 64'd0);
    endtask

    // Monitor: shift model sampled on the falling clk edge.
    initial begin
        logic [63:0] exp_frame;
        bitcnt     = 0;
        pen_len    = 0;
        pen_pulses = 0;
        done_cnt   = 0;
        shreg      = '0;
        prev_clk   = 1'b0;
        prev_dout  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bitcnt  = 0;
                pen_len = 0;
            end else begin
                if (seg_clk && !prev_clk) begin
                    chk(seg_dout == prev_dout, "dout_stable", 64'(seg_dout), 64'(prev_dout));
                    shreg = {shreg[62:0], seg_dout};
                    bitcnt++;
                end
                if (seg_pen) begin
                    if (pen_len == 0) chk(bitcnt == 64, "bits_before_pen", 64'(bitcnt), 64'd64);
                    pen_len++;
                    chk(!seg_clk, "clk_low_in_latch", 64'(seg_clk), 64'd0);
                end else if (pen_len != 0) begin
                    pen_pulses++;
                    chk(pen_len == CLK_DIV, "pen_width", 64'(pen_len), 64'(CLK_DIV));
                    chk(done && !busy, "done_after_latch", 64'({done, busy}), 64'h2);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "frame_unexpected", shreg, 64'd0);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        chk(shreg == exp_frame, "frame", shreg, exp_frame);
                    end
                    pen_len = 0;
                    bitcnt  = 0;
                end
                if (done) done_cnt++;
            end
            prev_clk  = seg_clk;
            prev_dout = seg_dout;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_pen;
        int saved_done;

        // Reset state.
        repeat (3) tick();
        chk(!busy,     "rst_busy",  64'(busy),     64'd0);
        chk(!done,     "rst_done",  64'(done),     64'd0);
        chk(!seg_clk,  "rst_clk",   64'(seg_clk),  64'd0);
        chk(!seg_dout, "rst_dout",  64'(seg_dout), 64'd0);
        chk(!seg_pen,  "rst_pen",   64'(seg_pen),  64'd0);
        chk(!seg_clrn, "rst_clrn",  64'(seg_clrn), 64'd0);

        // Release with score 000: last_sent=FFF forces a frame.
        exp_q.push_back(64'hFFFFFFFF_FFFFFFC0);
        rst = 1'b0;
        tick();
        chk(seg_clrn, "clrn_after_rst", 64'(seg_clrn), 64'd1);
        chk(busy, "busy_in_load", 64'(busy), 64'd1);
        wait_done(1, LAT, "lat_release");
        settle("idle_after_release");

        // Start together with a score change: one frame only.
        saved_pen = pen_pulses;
        exp_q.push_back(64'hFFFFFFFF_FFF9C092);
        fire(12'h105, 1'b1);
        wait_done(1, LAT, "lat_105");
        settle("idle_after_105");
        chk(pen_pulses == saved_pen + 1, "pen_count_105", 64'(pen_pulses), 64'(saved_pen + 1));

        // Start with unchanged score; a second start mid-frame is dropped.
        saved_pen = pen_pulses;
        exp_q.push_back(64'hFFFFFFFF_FFF9C092);
        fire(12'h105, 1'b1);
        repeat (40) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(42, LAT, "lat_restart");
        repeat (5) tick();
        chk(!busy, "start_dropped", 64'(busy), 64'd0);
        chk(pen_pulses == saved_pen + 1, "pen_count_drop", 64'(pen_pulses), 64'(saved_pen + 1));

        // Automatic frame on score change.
        exp_q.push_back(64'hFFFFFFFF_FFFFF982);
        fire(12'h016, 1'b0);
        wait_done(1, LAT, "lat_auto_016");
        settle("idle_after_016");

        // Score change mid-shift: current frame unchanged, next frame follows.
        exp_q.push_back(64'hFFFFFFFF_FFFFF982);
        fire(12'h016, 1'b1);
        wait_bits(20, "reach_bit20");
        score = 12'h009;
        exp_q.push_back(64'hFFFFFFFF_FFFFFF90);
        wait_done(0, -1, "done_016_again");
        wait_done(0, LAT + 1, "lat_retrigger_009");
        settle("idle_after_009");

        // Invalid tens digit shows a dash and is not blanked.
        exp_q.push_back(64'hFFFFFFFF_FFFFBFB0);
        fire(12'h0A3, 1'b0);
        wait_done(1, LAT, "lat_0a3");
        settle("idle_after_0a3");

        exp_q.push_back(64'hFFFFFFFF_FF909090);
        fire(12'h999, 1'b1);
        wait_done(1, LAT, "lat_999");
        settle("idle_after_999");

        exp_q.push_back(64'hFFFFFFFF_FFFFBFC0);
        fire(12'h0F0, 1'b0);
        wait_done(1, LAT, "lat_0f0");
        settle("idle_after_0f0");

        // Reset mid-frame aborts it; a fresh frame follows release.
        fire(12'h250, 1'b0);
        wait_bits(30, "reach_bit30");
        saved_pen  = pen_pulses;
        saved_done = done_cnt;
        rst = 1'b1;
        repeat (3) tick();
        chk(!seg_clrn, "abort_clrn", 64'(seg_clrn), 64'd0);
        chk(!busy,     "abort_busy", 64'(busy),     64'd0);
        chk(!seg_pen,  "abort_pen",  64'(seg_pen),  64'd0);
        chk(!seg_clk,  "abort_clk",  64'(seg_clk),  64'd0);
        chk(pen_pulses == saved_pen, "abort_no_pen", 64'(pen_pulses), 64'(saved_pen));
        chk(done_cnt == saved_done, "abort_no_done", 64'(done_cnt), 64'(saved_done));
        exp_q.push_back(64'hFFFFFFFF_FFA492C0);
        rst = 1'b0;
        wait_done(0, LAT, "lat_after_abort");
        settle("idle_after_abort");
        chk(pen_pulses == saved_pen + 1, "pen_count_abort", 64'(pen_pulses), 64'(saved_pen + 1));

        chk(exp_q.size() == 0, "queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
